// File: rtl/cfg_pkg.sv
// ----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration loader: default word and chain
// sizes and the loader FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package cfg_pkg;

   // Default width of one configuration word on the input bus.
   localparam int DEF_WORD_W    = 8;
   // Default total length of the CLB scan chain.
   localparam int DEF_CHAIN_LEN = 40;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_COMMIT = 2'd3
   } cfg_state_e;

endpackage : cfg_pkg

// File: rtl/cfg_loader_if.sv
// ----------------------------------------------------------------------------
// cfg_loader_if
// Bundles the loader's control, word-input handshake and scan-chain outputs.
//   master : producer/controller side (drives start, in_valid, in_data)
//   slave  : cfg_loader side (drives in_ready, scan_en, scan_out,
//            cfg_commit, busy, done)
// Parameter WORD_W : width of in_data.
// ----------------------------------------------------------------------------
interface cfg_loader_if
   import cfg_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) ();

   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              scan_en;
   logic              scan_out;
   logic              cfg_commit;
   logic              busy;
   logic              done;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, scan_en, scan_out, cfg_commit, busy, done
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, scan_en, scan_out, cfg_commit, busy, done
   );

endinterface : cfg_loader_if

// File: rtl/cfg_shifter.sv
// ----------------------------------------------------------------------------
// cfg_shifter
// Parallel-load, LSB-first shift register with a total-bit counter and a
// per-word bit counter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr_i          : clear the total bit counter (start of a new load)
//   load_i         : load data_i into the shift register
//   shift_i        : shift right by one, count the bit
//   data_i         : word to load
//   bit0_o         : current LSB (next bit to go onto the chain)
//   word_last_o    : the bit in bit0_o is the last bit of the current word
//   chain_last_o   : the bit in bit0_o is the last bit of the chain
// ----------------------------------------------------------------------------
module cfg_shifter
   import cfg_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [WORD_W-1:0] data_i,
   output logic              bit0_o,
   output logic              word_last_o,
   output logic              chain_last_o
);

   // Sized so the total count can reach CHAIN_LEN without wrapping.
   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam int WCNT_W = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0] shifted;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   // Right-shift with zero fill at the MSB.
   genvar gi;
   generate
      for (gi = 0; gi < WORD_W; gi++) begin : g_shift
         if (gi == WORD_W - 1) begin : g_msb
            assign shifted[gi] = 1'b0;
         end else begin : g_bit
            assign shifted[gi] = shift_q[gi+1];
         end
      end
   endgenerate

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end
      if (load_i) begin
         shift_d = data_i;
         wcnt_d  = '0;
      end else if (shift_i) begin
         shift_d = shifted;
         wcnt_d  = wcnt_q + 1'b1;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign bit0_o       = shift_q[0];
   assign word_last_o  = (wcnt_q == WCNT_W'(WORD_W - 1));
   assign chain_last_o = (cnt_q == CNT_W'(CHAIN_LEN - 1));

endmodule : cfg_shifter

// File: rtl/cfg_loader.sv
// ----------------------------------------------------------------------------
// cfg_loader
// Accepts configuration words over a valid/ready handshake and shifts them,
// LSB first, into a CLB scan chain of CHAIN_LEN bits, then strobes
// cfg_commit and raises the sticky done flag.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset (aborts any load in progress)
//   bus    : cfg_loader_if.slave
//            start, in_valid, in_data in; in_ready, scan_en, scan_out,
//            cfg_commit, busy, done out
// ----------------------------------------------------------------------------
module cfg_loader
   import cfg_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
   input  logic         clk,
   input  logic         rst_n,
   cfg_loader_if.slave  bus
);

   cfg_state_e state_q, state_d;
   logic       done_q, done_d;

   logic in_ready;
   logic scan_en;
   logic cfg_commit;
   logic sh_clr;
   logic sh_load;
   logic sh_shift;
   logic sh_bit0;
   logic sh_word_last;
   logic sh_chain_last;

   cfg_shifter #(
      .WORD_W    (WORD_W),
      .CHAIN_LEN (CHAIN_LEN)
   ) u_shifter (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (sh_clr),
      .load_i       (sh_load),
      .shift_i      (sh_shift),
      .data_i       (bus.in_data),
      .bit0_o       (sh_bit0),
      .word_last_o  (sh_word_last),
      .chain_last_o (sh_chain_last)
   );

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      in_ready   = 1'b0;
      scan_en    = 1'b0;
      cfg_commit = 1'b0;
      sh_clr     = 1'b0;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               done_d  = 1'b0;
               sh_clr  = 1'b1;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               sh_load = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            scan_en  = 1'b1;
            sh_shift = 1'b1;
            // Chain end takes priority over word end: the unused high bits
            // of a final partial word are simply dropped.
            if (sh_chain_last) begin
               state_d = ST_COMMIT;
            end else if (sh_word_last) begin
               state_d = ST_LOAD;
            end
         end
         ST_COMMIT: begin
            cfg_commit = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.scan_en    = scan_en;
   // Gated so the chain input is quiet whenever it is not shifting.
   assign bus.scan_out   = scan_en & sh_bit0;
   assign bus.cfg_commit = cfg_commit;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = done_q;

endmodule : cfg_loader
